// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: RV32 opcode classes, hazard FSM encoding and
// source-register usage helpers used by both the decoder and hazard control.
package pipe_pkg;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FREEZE = 2'd2
   } hz_state_e;

   function automatic logic reads_rs1(input logic [6:0] op);
      return op inside {OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH};
   endfunction

   // I-type ALU ops and loads carry an immediate in the rs2 field
   function automatic logic reads_rs2(input logic [6:0] op);
      return op inside {OP_RTYPE, OP_STORE, OP_BRANCH};
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard control bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface hazard_ctrl_if;
   logic [6:0]  Op_i;
   logic [4:0]  RS1addr_i;
   logic [4:0]  RS2addr_i;
   logic        EX_MemRead_i;
   logic [4:0]  EX_RDaddr_i;
   logic        Branch_taken_i;
   logic        mem_stall_i;
   logic        NoOp_o;
   logic        Stall_o;
   logic        PCWrite_o;
   logic        Flush_o;
   logic        Freeze_o;
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;
   logic [31:0] freeze_cnt_o;

   modport master (
      output Op_i, RS1addr_i, RS2addr_i, EX_MemRead_i, EX_RDaddr_i,
             Branch_taken_i, mem_stall_i,
      input  NoOp_o, Stall_o, PCWrite_o, Flush_o, Freeze_o,
             stall_cnt_o, flush_cnt_o, freeze_cnt_o
   );

   modport slave (
      input  Op_i, RS1addr_i, RS2addr_i, EX_MemRead_i, EX_RDaddr_i,
             Branch_taken_i, mem_stall_i,
      output NoOp_o, Stall_o, PCWrite_o, Flush_o, Freeze_o,
             stall_cnt_o, flush_cnt_o, freeze_cnt_o
   );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use check: the EX load writes a register the ID
// instruction actually reads (x0 never creates a dependency).
module load_use_detect
   import pipe_pkg::*;
(
   input  logic [6:0] op,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   output logic       load_use
);

   always_comb begin
      load_use = 1'b0;
      if (ex_mem_read && (ex_rd != 5'd0)) begin
         if (reads_rs1(op) && (rs1 == ex_rd)) load_use = 1'b1;
         if (reads_rs2(op) && (rs2 == ex_rd)) load_use = 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: reset fill bubble, memory freeze, load-use
// stall and taken-branch flush, with saturating event counters.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   hazard_ctrl_if.slave  hz
);

   hz_state_e        state, state_next;
   logic             load_use;
   logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + CNT_W'(1);
   endfunction

   load_use_detect u_lud (
      .op          (hz.Op_i),
      .rs1         (hz.RS1addr_i),
      .rs2         (hz.RS2addr_i),
      .ex_mem_read (hz.EX_MemRead_i),
      .ex_rd       (hz.EX_RDaddr_i),
      .load_use    (load_use)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) state <= ST_FILL;
      else        state <= state_next;
   end

   always_comb begin
      state_next = ST_FILL;
      case (state)
         ST_FILL:           state_next = ST_RUN;
         ST_RUN, ST_FREEZE: state_next = hz.mem_stall_i ? ST_FREEZE : ST_RUN;
         default:           state_next = ST_FILL;
      endcase
   end

   // FREEZE releases combinationally: the first idle-memory cycle already
   // evaluates hazards exactly like RUN
   always_comb begin
      hz.NoOp_o    = 1'b0;
      hz.Stall_o   = 1'b0;
      hz.Flush_o   = 1'b0;
      hz.Freeze_o  = 1'b0;
      hz.PCWrite_o = 1'b1;
      if (!rst_i) begin
         hz.NoOp_o    = 1'b1;
         hz.PCWrite_o = 1'b0;
      end else begin
         case (state)
            ST_FILL: hz.NoOp_o = 1'b1;
            ST_RUN, ST_FREEZE: begin
               if (hz.mem_stall_i) begin
                  hz.Freeze_o  = 1'b1;
                  hz.PCWrite_o = 1'b0;
               end else if (load_use) begin
                  hz.NoOp_o    = 1'b1;
                  hz.Stall_o   = 1'b1;
                  hz.PCWrite_o = 1'b0;
               end else if (hz.Branch_taken_i) begin
                  hz.Flush_o = 1'b1;
               end
            end
            default: hz.NoOp_o = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         freeze_cnt <= '0;
      end else begin
         if (hz.Stall_o)  stall_cnt  <= sat_inc(stall_cnt);
         if (hz.Flush_o)  flush_cnt  <= sat_inc(flush_cnt);
         if (hz.Freeze_o) freeze_cnt <= sat_inc(freeze_cnt);
      end
   end

   assign hz.stall_cnt_o  = 32'(stall_cnt);
   assign hz.flush_cnt_o  = 32'(flush_cnt);
   assign hz.freeze_cnt_o = 32'(freeze_cnt);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by
// random traffic; a narrow-counter twin instance exercises saturation.
module tb_hazard_ctrl;

   typedef struct packed {
      int          cyc;
      logic [4:0]  ctl;   // {NoOp, Stall, PCWrite, Flush, Freeze}
      logic [31:0] sc, fc, zc;
      logic [1:0]  sc2, fc2, zc2;
   } exp_t;

   logic clk = 1'b0;
   logic rst_i;
   always #5 clk = ~clk;

   hazard_ctrl_if hz ();
   hazard_ctrl_if hz2 ();

   hazard_ctrl #(.CNT_W(32)) dut (.clk_i(clk), .rst_i(rst_i), .hz(hz));
   hazard_ctrl #(.CNT_W(2))  dut2 (.clk_i(clk), .rst_i(rst_i), .hz(hz2));

   assign hz2.Op_i           = hz.Op_i;
   assign hz2.RS1addr_i      = hz.RS1addr_i;
   assign hz2.RS2addr_i      = hz.RS2addr_i;
   assign hz2.EX_MemRead_i   = hz.EX_MemRead_i;
   assign hz2.EX_RDaddr_i    = hz.EX_RDaddr_i;
   assign hz2.Branch_taken_i = hz.Branch_taken_i;
   assign hz2.mem_stall_i    = hz.mem_stall_i;

   exp_t   sb[$];
   int     n_chk = 0;
   int     n_fail = 0;
   int     cyc = 0;
   longint n_stall = 0, n_flush = 0, n_frz = 0;
   logic   prev_rst = 1'b0;

   logic [6:0] ops [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b1101111, 7'b0110111};

   function automatic logic [31:0] sat32(input longint n);
      return (n > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : n[31:0];
   endfunction

   function automatic logic [1:0] sat2(input longint n);
      return (n > 3) ? 2'd3 : n[1:0];
   endfunction

   task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL cycle %0d %s: got %h expected %h", c, name, got, want);
      end
   endtask

   // One pipeline cycle: apply inputs and queue what the rules demand
   task automatic drive(input logic rst, input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic mr, input logic [4:0] rd,
                        input logic br, input logic ms);
      exp_t e;
      logic uses1, uses2, lu, fill;
      logic noop, stall, pcw, flush, frz;
      @(posedge clk);
      #1;
      rst_i = rst;
      hz.Op_i = op; hz.RS1addr_i = rs1; hz.RS2addr_i = rs2;
      hz.EX_MemRead_i = mr; hz.EX_RDaddr_i = rd;
      hz.Branch_taken_i = br; hz.mem_stall_i = ms;

      uses1 = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
              (op == 7'b0100011) || (op == 7'b1100011);
      uses2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
      lu    = mr && (rd != 5'd0) && ((uses1 && rs1 == rd) || (uses2 && rs2 == rd));
      fill  = rst && !prev_rst;

      {noop, stall, pcw, flush, frz} = 5'b00100;
      if (!rst)     {noop, pcw} = 2'b10;
      else if (fill) noop = 1'b1;
      else if (ms)  {frz, pcw} = 2'b10;
      else if (lu)  {noop, stall, pcw} = 3'b110;
      else if (br)  flush = 1'b1;

      e.cyc = cyc;
      e.ctl = {noop, stall, pcw, flush, frz};
      e.sc  = sat32(n_stall);  e.fc  = sat32(n_flush);  e.zc  = sat32(n_frz);
      e.sc2 = sat2(n_stall);   e.fc2 = sat2(n_flush);   e.zc2 = sat2(n_frz);
      sb.push_back(e);

      if (!rst) begin
         n_stall = 0; n_flush = 0; n_frz = 0;
      end else begin
         n_stall += longint'(stall);
         n_flush += longint'(flush);
         n_frz   += longint'(frz);
      end
      prev_rst = rst;
      cyc++;
   endtask

   task automatic idle();
      drive(1'b1, 7'b0010011, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ctl{noop,stall,pcw,flush,freeze}", e.cyc,
                {27'd0, hz.NoOp_o, hz.Stall_o, hz.PCWrite_o, hz.Flush_o, hz.Freeze_o},
                {27'd0, e.ctl});
            chk("stall_cnt",  e.cyc, hz.stall_cnt_o,  e.sc);
            chk("flush_cnt",  e.cyc, hz.flush_cnt_o,  e.fc);
            chk("freeze_cnt", e.cyc, hz.freeze_cnt_o, e.zc);
            chk("sat_stall_cnt",  e.cyc, hz2.stall_cnt_o,  {30'd0, e.sc2});
            chk("sat_flush_cnt",  e.cyc, hz2.flush_cnt_o,  {30'd0, e.fc2});
            chk("sat_freeze_cnt", e.cyc, hz2.freeze_cnt_o, {30'd0, e.zc2});
         end
      end
   end

   initial begin : stimulus
      rst_i = 1'b0;
      hz.Op_i = 7'b0010011; hz.RS1addr_i = 5'd0; hz.RS2addr_i = 5'd0;
      hz.EX_MemRead_i = 1'b0; hz.EX_RDaddr_i = 5'd0;
      hz.Branch_taken_i = 1'b0; hz.mem_stall_i = 1'b0;

      // reset held three cycles, then the fill bubble and normal flow
      repeat (3) drive(1'b0, 7'b0010011, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      idle();
      idle();
      // R-type reading the load target through rs2, then I-ALU with rs2 ignored
      drive(1'b1, 7'b0110011, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
      drive(1'b1, 7'b0010011, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
      // x0 target never stalls
      drive(1'b1, 7'b0110011, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
      // dependent taken branch stalls, then flushes on re-resolution
      drive(1'b1, 7'b1100011, 5'd3, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
      drive(1'b1, 7'b1100011, 5'd3, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
      // memory busy for four cycles over a load-use, then the stall resumes
      repeat (4) drive(1'b1, 7'b0110011, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1, 1'b1);
      drive(1'b1, 7'b0110011, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);
      // more stalls drive the narrow twin into saturation
      repeat (3) drive(1'b1, 7'b0100011, 5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
      idle();
      // reset in the middle of a freeze
      repeat (2) drive(1'b1, 7'b0010011, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      drive(1'b0, 7'b0010011, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      drive(1'b1, 7'b0110011, 5'd4, 5'd4, 1'b1, 5'd4, 1'b1, 1'b1);
      idle();
      idle();

      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 79) != 0),
               ops[$urandom_range(0, 6)],
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2));
      end

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", cyc, 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk_i  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous active-low reset.
REQ-004 Op_i  input  7  opcode of the instruction in ID.
REQ-005 RS1addr_i / RS2addr_i  input  5 each  source register indices of the ID instruction.
REQ-006 EX_MemRead_i  input  1  instruction in EX is a load.
REQ-007 EX_RDaddr_i  input  5  destination register of the EX instruction.
REQ-008 Branch_taken_i  input  1  beq in ID resolved taken (Branch and equal).
REQ-009 mem_stall_i  input  1  data memory busy; the MEM access is not complete this cycle.
REQ-010 NoOp_o  output  1  drives the decoder NoOp input; forces a bubble into ID/EX.
REQ-011 Stall_o  output  1  hold IF/ID register.
REQ-012 PCWrite_o  output  1  PC update enable.
REQ-013 Flush_o  output  1  clear IF/ID to a nop.
REQ-014 Freeze_o  output  1  hold every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
REQ-015 stall_cnt_o / flush_cnt_o / freeze_cnt_o  output  32 each  event counters.

Function
REQ-016 The state machine SHALL have states FILL, RUN and FREEZE; control outputs are combinational from state and current inputs; counters are registered.
REQ-017 FILL SHALL last exactly one cycle after reset release: NoOp_o=1, PCWrite_o=1, Stall_o=0, Flush_o=0, Freeze_o=0; next state RUN unconditionally.
REQ-018 In RUN with mem_stall_i=1, the block SHALL assert Freeze_o=1, PCWrite_o=0, Stall_o=0, NoOp_o=0 and Flush_o=0 in that same cycle, and enter FREEZE.
REQ-019 In FREEZE, the outputs SHALL match REQ-018 while mem_stall_i=1; in the first cycle with mem_stall_i=0 the block SHALL evaluate as RUN (REQ-020..022) and return to RUN, so freeze costs no extra cycle.
REQ-020 Load-use SHALL be detected when EX_MemRead_i=1 and EX_RDaddr_i!=0 and the ID instruction reads that register, with reads defined as:
- RS1addr_i for opcodes 0110011, 0010011, 0000011, 0100011 and 1100011;
- RS2addr_i for opcodes 0110011, 0100011 and 1100011 only;
- no source register for any other opcode.
REQ-021 On load-use, with no freeze condition, the block SHALL assert NoOp_o=1, Stall_o=1 and PCWrite_o=0 for exactly that cycle.
REQ-022 On Branch_taken_i=1 with no freeze and no load-use, the block SHALL assert Flush_o=1 and PCWrite_o=1.
REQ-023 Priority SHALL be freeze > load-use > flush. A taken branch that depends on a load SHALL stall without flushing; the branch is re-resolved in the next cycle.
REQ-024 With no event, outputs SHALL be NoOp_o=0, Stall_o=0, Flush_o=0, Freeze_o=0, PCWrite_o=1.
REQ-025 Counters SHALL increment by 1 on the clock edge ending each cycle whose output is asserted:
- stall_cnt_o per load-use stall cycle (REQ-021 applied);
- flush_cnt_o per Flush_o cycle;
- freeze_cnt_o per Freeze_o cycle.
REQ-026 Each counter SHALL saturate at 0xFFFF_FFFF and never wrap.
REQ-027 Outputs in FILL SHALL be as in REQ-017, regardless of inputs.

Reset
REQ-028 While rst_i=0 the block SHALL drive NoOp_o=1, PCWrite_o=0, Stall_o=0, Flush_o=0 and Freeze_o=0.
REQ-029 On any clock edge with rst_i=0 the block SHALL set the state to FILL and clear all counters to 0, including reset asserted mid-FREEZE or mid-stall.
REQ-030 The first rising edge with rst_i=1 SHALL leave the block in FILL for one cycle.

Structure
REQ-031 Opcode constants (R-type, I-ALU, load, store, branch) and the state encoding SHALL live in the shared package pipe_pkg, which the decoder also imports.
REQ-032 Load-use comparison SHALL be a combinational sub-module named load_use_detect; the FSM, priority logic and counters remain in hazard_ctrl.

Verification
REQ-033 Reset then release: rst_i=0 for 3 cycles then 1 -> one cycle NoOp_o=1, PCWrite_o=1, then NoOp_o=0; all counters 0.
REQ-034 EX load with rd=5; ID Op=0110011, rs2=5 -> NoOp_o=1, Stall_o=1, PCWrite_o=0 for 1 cycle; stall_cnt_o=1. Repeat with Op=0010011, rs2=5 -> no stall.
REQ-035 EX load with rd=0; ID rs1=0 -> no stall.
REQ-036 Branch_taken_i=1 with EX load rd=3 and ID beq rs1=3 -> stall only, Flush_o=0. Next cycle (load in MEM) with Branch_taken_i=1 -> Flush_o=1; flush_cnt_o=1.
REQ-037 mem_stall_i=1 for 4 cycles during a load-use condition -> Freeze_o=1, NoOp_o=0, PCWrite_o=0 for 4 cycles; freeze_cnt_o=4; the 5th cycle evaluates load-use normally.
REQ-038 Force stall_cnt_o to 0xFFFF_FFFE, then 3 load-use cycles -> counter holds 0xFFFF_FFFF. rst_i=0 mid-FREEZE -> FILL next, counters 0.
